// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the hazard/memory side and the pipeline controller.
// The controller uses the slave modport. The source of stalls and the consumer of enables use master.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             stallFD;
  logic             branch_taken_D;
  logic             halt_D;
  logic             imem_stall;
  logic             dmem_stall;
  logic             pc_en;
  logic             pc_redirect;
  logic             use_saved_tgt;
  logic             save_tgt;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic             memwb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output stallFD, branch_taken_D, halt_D, imem_stall, dmem_stall,
    input  pc_en, pc_redirect, use_saved_tgt, save_tgt, ifid_en, ifid_flush,
           idex_en, idex_flush, exmem_en, memwb_en, memwb_flush, halted, stall_cnt
  );

  modport slave (
    input  stallFD, branch_taken_D, halt_D, imem_stall, dmem_stall,
    output pc_en, pc_redirect, use_saved_tgt, save_tgt, ifid_en, ifid_flush,
           idex_en, idex_flush, exmem_en, memwb_en, memwb_flush, halted, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline register enable/flush controller.
// It handles the pending branch redirect, the HLT drain sequencer and the saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.slave    bus
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             halted_q, halted_d;

  logic pc_en_s, pc_redirect_s, use_saved_s, save_tgt_s;
  logic ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s;
  logic exmem_en_s, memwb_en_s, memwb_flush_s;

  always_comb begin
    pc_en_s       = 1'b1;
    pc_redirect_s = 1'b0;
    use_saved_s   = 1'b0;
    save_tgt_s    = 1'b0;
    ifid_en_s     = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_en_s     = 1'b1;
    idex_flush_s  = 1'b0;
    exmem_en_s    = 1'b1;
    memwb_en_s    = 1'b1;
    memwb_flush_s = 1'b0;
    state_d       = state_q;
    pend_d        = pend_q;
    drain_d       = drain_q;
    halted_d      = halted_q;

    case (state_q)
      ST_RUN: begin
        if (bus.dmem_stall) begin
          // Everything upstream of WB freezes; a bubble enters WB.
          pc_en_s       = 1'b0;
          ifid_en_s     = 1'b0;
          idex_en_s     = 1'b0;
          exmem_en_s    = 1'b0;
          memwb_flush_s = 1'b1;
        end else if (bus.stallFD) begin
          pc_en_s      = 1'b0;
          ifid_en_s    = 1'b0;
          idex_flush_s = 1'b1;
        end else if (bus.halt_D) begin
          pc_en_s      = 1'b0;
          ifid_flush_s = 1'b1;
          pend_d       = 1'b0;
          drain_d      = DW'(1);
          if (DRAIN_CYCLES <= 1) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d  = ST_DRAIN;
          end
        end else if (bus.branch_taken_D) begin
          ifid_flush_s = 1'b1;
          if (!bus.imem_stall) begin
            pc_redirect_s = 1'b1;
            pend_d        = 1'b0;
          end else begin
            // The target is latched now and applied once the fetch completes.
            pc_en_s    = 1'b0;
            save_tgt_s = 1'b1;
            pend_d     = 1'b1;
          end
        end else if (pend_q) begin
          ifid_flush_s = 1'b1;
          if (!bus.imem_stall) begin
            pc_redirect_s = 1'b1;
            use_saved_s   = 1'b1;
            pend_d        = 1'b0;
          end else begin
            pc_en_s = 1'b0;
          end
        end else if (bus.imem_stall) begin
          pc_en_s      = 1'b0;
          ifid_flush_s = 1'b1;
        end else begin
          pc_en_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        pc_en_s = 1'b0;
        pend_d  = 1'b0;
        if (bus.dmem_stall) begin
          ifid_en_s     = 1'b0;
          idex_en_s     = 1'b0;
          exmem_en_s    = 1'b0;
          memwb_flush_s = 1'b1;
        end else begin
          ifid_flush_s = 1'b1;
          drain_d      = drain_q + DW'(1);
          if (int'(drain_q) + 1 >= DRAIN_CYCLES) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d  = ST_DRAIN;
          end
        end
      end
      ST_HALTED: begin
        pc_en_s    = 1'b0;
        ifid_en_s  = 1'b0;
        idex_en_s  = 1'b0;
        exmem_en_s = 1'b0;
        memwb_en_s = 1'b0;
        halted_d   = 1'b1;
      end
      default: begin
        state_d  = ST_RUN;
        pend_d   = 1'b0;
        drain_d  = {DW{1'b0}};
        halted_d = 1'b0;
      end
    endcase

    if (state_q != ST_HALTED && !pc_en_s && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Controller state, drain progress, redirect flag and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pend_q      <= 1'b0;
      drain_q     <= {DW{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.pc_en         = pc_en_s;
  assign bus.pc_redirect   = pc_redirect_s;
  assign bus.use_saved_tgt = use_saved_s;
  assign bus.save_tgt      = save_tgt_s;
  assign bus.ifid_en       = ifid_en_s;
  assign bus.ifid_flush    = ifid_flush_s;
  assign bus.idex_en       = idex_en_s;
  assign bus.idex_flush    = idex_flush_s;
  assign bus.exmem_en      = exmem_en_s;
  assign bus.memwb_en      = memwb_en_s;
  assign bus.memwb_flush   = memwb_flush_s;
  assign bus.halted        = halted_q;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed table-driven bench for pipe_ctrl with hand-written redirect, drain and saturation sequences.
module tb_pipe_ctrl;

  localparam logic [10:0] O_NORM  = 11'b100_0101_0110;
  localparam logic [10:0] O_DMEM  = 11'b000_0000_0011;
  localparam logic [10:0] O_STALL = 11'b000_0001_1110;
  localparam logic [10:0] O_IMEM  = 11'b000_0111_0110;
  localparam logic [10:0] O_BRL   = 11'b110_0111_0110;
  localparam logic [10:0] O_BRS   = 11'b000_1111_0110;
  localparam logic [10:0] O_PRES  = 11'b111_0111_0110;
  localparam logic [10:0] O_HALTD = 11'b000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        cur_halted = 1'b0;

  pipe_ctrl_if #(.CNT_W(16)) bus ();

  pipe_ctrl #(.CNT_W(16), .DRAIN_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  in;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [10:0] outs();
    return {bus.pc_en, bus.pc_redirect, bus.use_saved_tgt, bus.save_tgt,
            bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
            bus.exmem_en, bus.memwb_en, bus.memwb_flush};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] v);
    {bus.stallFD, bus.branch_taken_D, bus.halt_D, bus.imem_stall, bus.dmem_stall} = v;
  endtask

  // One clock: drive, check combinational outputs, clock, check registered state.
  task automatic cycle(input string nm, input logic [4:0] in, input logic [10:0] exp_o,
                       input logic exp_h_after);
    @(negedge clk);
    set_in(in);
    #1;
    chk({nm, ".outs"}, 32'(outs()), 32'(exp_o));
    @(posedge clk);
    #1;
    if (!exp_o[10] && !cur_halted && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    cur_halted = exp_h_after;
    chk({nm, ".cnt"}, 32'(bus.stall_cnt), 32'(exp_cnt));
    chk({nm, ".halted"}, 32'(bus.halted), 32'(exp_h_after));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(5'b00000);
    #1;
    chk("rst.outs", 32'(outs()), 32'(O_NORM));
    chk("rst.halted", 32'(bus.halted), 32'd0);
    chk("rst.cnt", 32'(bus.stall_cnt), 32'd0);
    exp_cnt = 16'd0;
    cur_halted = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // inputs: {stallFD, branch_taken_D, halt_D, imem_stall, dmem_stall}
    vecs[0]  = '{"idle",        5'b00000, O_NORM};
    vecs[1]  = '{"stallFD",     5'b10000, O_STALL};
    vecs[2]  = '{"dmem",        5'b00001, O_DMEM};
    vecs[3]  = '{"dmem_st_br",  5'b11001, O_DMEM};
    vecs[4]  = '{"dmem_br_im",  5'b01011, O_DMEM};
    vecs[5]  = '{"idle2",       5'b00000, O_NORM};
    vecs[6]  = '{"imem",        5'b00010, O_IMEM};
    vecs[7]  = '{"br_live",     5'b01000, O_BRL};
    vecs[8]  = '{"st_br_im",    5'b11010, O_STALL};
    vecs[9]  = '{"st_halt",     5'b10100, O_STALL};
    vecs[10] = '{"dmem_halt",   5'b00101, O_DMEM};
    vecs[11] = '{"idle3",       5'b00000, O_NORM};

    set_in(5'b00000);
    #1;
    chk("rst0.outs", 32'(outs()), 32'(O_NORM));
    chk("rst0.cnt", 32'(bus.stall_cnt), 32'd0);
    do_reset();

    for (int i = 0; i < 12; i++) cycle(vecs[i].name, vecs[i].in, vecs[i].exp, 1'b0);

    // Branch during fetch stall: saved target applied once fetch completes.
    cycle("brs.c0", 5'b01010, O_BRS,  1'b0);
    cycle("brs.c1", 5'b00010, O_IMEM, 1'b0);
    cycle("brs.c2", 5'b00000, O_PRES, 1'b0);
    cycle("brs.c3", 5'b00000, O_NORM, 1'b0);

    // Reset while a redirect is pending must discard it.
    cycle("pend.set", 5'b01010, O_BRS, 1'b0);
    do_reset();
    cycle("pend.gone", 5'b00000, O_NORM, 1'b0);

    // HLT drain with a data stall on the second drain cycle.
    cycle("hlt.c0", 5'b00100, O_IMEM, 1'b0);
    cycle("hlt.c1", 5'b00000, O_IMEM, 1'b0);
    cycle("hlt.c2", 5'b00001, O_DMEM, 1'b0);
    cycle("hlt.c3", 5'b11000, O_IMEM, 1'b1);
    cycle("hlt.c4", 5'b11111, O_HALTD, 1'b1);
    cycle("hlt.c5", 5'b00000, O_HALTD, 1'b1);
    do_reset();

    // Saturate the stall counter.
    @(negedge clk);
    set_in(5'b10000);
    for (int i = 0; i < 65541; i++) @(posedge clk);
    #1;
    chk("sat.cnt", 32'(bus.stall_cnt), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    cycle("sat.idle", 5'b00000, O_NORM, 1'b0);
    cycle("sat.hlt", 5'b00100, O_IMEM, 1'b0);

    // Asynchronous reset in the middle of the drain.
    @(negedge clk);
    set_in(5'b00000);
    #1;
    chk("drain.outs", 32'(outs()), 32'(O_IMEM));
    rst = 1'b1;
    #1;
    chk("arst.outs", 32'(outs()), 32'(O_NORM));
    chk("arst.halted", 32'(bus.halted), 32'd0);
    chk("arst.cnt", 32'(bus.stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'd0;
    cur_halted = 1'b0;
    cycle("post.idle", 5'b00000, O_NORM, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Consumer of the hazard/forwarding unit's stall request in the five-stage pipeline.
- Merges stallFD, decode-stage taken-branch and HLT, and instruction/data memory busy signals into per-register enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Holds a pending-redirect flag for branches that coincide with a fetch stall.
- Sequences the HLT drain and provides a stall-cycle performance counter.

Parameters:
CNT_W, 16, width of saturating stall-cycle counter
DRAIN_CYCLES, 3, advancing edges for HLT to travel D->W

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
stallFD  input  1  load-use stall request from hazard unit
branch_taken_D  input  1  branch in D resolved taken this cycle
halt_D  input  1  HLT present in D
imem_stall  input  1  fetch not complete this cycle
dmem_stall  input  1  data access not complete this cycle
pc_en  output  1  PC register load enable
pc_redirect  output  1  PC loads branch target (live or saved) instead of PC+2
use_saved_tgt  output  1  datapath selects target latched at branch time
save_tgt  output  1  datapath latches current branch target
ifid_en  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID loads bubble
idex_en  output  1  ID/EX load enable
idex_flush  output  1  ID/EX loads bubble
exmem_en  output  1  EX/MEM load enable
memwb_en  output  1  MEM/WB load enable
memwb_flush  output  1  MEM/WB loads bubble
halted  output  1  HLT has reached WB; sticky until reset
stall_cnt  output  CNT_W  cycles with pc_en=0 while RUN/DRAIN, saturating

Behaviour:
- Reset (async, immediate): state=RUN, redirect_pending=0, drain_cnt=0, stall_cnt=0, halted=0. Combinational outputs take the values given by the RUN rules.
- Outputs are combinational from inputs and state; only state, counters and redirect_pending are registered.
- Priority in RUN, highest first: dmem_stall > stallFD > halt_D > branch_taken_D > redirect_pending > imem_stall > normal.
- dmem_stall:
  - pc_en, ifid_en, idex_en, exmem_en = 0.
  - memwb_en=1, memwb_flush=1 (bubble into WB).
  - All other flushes 0.
  - redirect_pending and drain_cnt hold.
- stallFD:
  - pc_en=0, ifid_en=0.
  - idex_en=1, idex_flush=1.
  - exmem_en=1, memwb_en=1.
- halt_D:
  - pc_en=0, ifid_en=1, ifid_flush=1.
  - Later stages advance.
  - Next state DRAIN, drain_cnt=1.
  - A simultaneous branch_taken_D is ignored.
- branch_taken_D:
  - ifid_en=1, ifid_flush=1 (squash the wrong-path fetch); later stages advance.
  - If imem_stall=0: pc_en=1, pc_redirect=1, use_saved_tgt=0.
  - If imem_stall=1: pc_en=0, save_tgt=1, redirect_pending<=1.
- redirect_pending=1:
  - ifid_en=1, ifid_flush=1; later stages advance.
  - If imem_stall=0: pc_en=1, pc_redirect=1, use_saved_tgt=1, and redirect_pending<=0.
  - Otherwise pc_en=0 and redirect_pending is kept.
- imem_stall alone: pc_en=0, ifid_en=1, ifid_flush=1, later stages advance.
- Normal: all enables 1, all flushes 0, pc_redirect=0.
- DRAIN:
  - pc_en=0, ifid_en=1, ifid_flush=1 every cycle; stallFD and branch_taken_D are ignored.
  - dmem_stall behaves as in RUN and freezes drain_cnt.
  - On each advancing edge drain_cnt increments.
  - When drain_cnt reaches DRAIN_CYCLES: state HALTED, halted<=1.
  - redirect_pending is cleared on entry to DRAIN.
- HALTED: all enables 0, all flushes 0, halted=1. Exit only by rst.
- stall_cnt increments on each edge where state!=HALTED and pc_en=0; saturates at all-ones.
- rst asserted mid-drain or while redirect_pending=1: all state clears at once; no redirect is applied after reset.

Test Plan:
- Reset then idle: all enables 1, flushes 0, halted=0, stall_cnt=0.
- stallFD=1 for 1 cycle: that cycle pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_cnt=1 after the edge.
- branch_taken_D with imem_stall=1 for 2 cycles then 0:
  - Cycle 0: save_tgt=1, ifid_flush=1, pc_en=0.
  - Cycle 1: pc_en=0.
  - Cycle 2: pc_en=1, pc_redirect=1, use_saved_tgt=1.
  - Cycle 3: redirect_pending=0.
- dmem_stall concurrent with stallFD and branch_taken_D: dmem rule wins (memwb_flush=1, all upstream enables 0, no save_tgt).
- halt_D with dmem_stall=1 on the second drain cycle: halted rises on the 4th edge after HLT, not the 3rd; afterwards all enables stay 0.
- Force 2^16+5 stall cycles with CNT_W=16: stall_cnt=16'hFFFF; assert rst during DRAIN: halted=0, state RUN immediately.
